// File: rtl/opl_pkg.sv
// Shared definitions for the OPL per-slot parameter ring controllers.
package opl_pkg;

  // Default ring length and the width of a slot index.
  localparam int SLOTS_DEF = 18;
  localparam int SLOT_W    = 5;

  // Write-side controller states.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2
  } ring_state_t;

  // Index of the last slot, truncated to a slot index.
  function automatic logic [SLOT_W-1:0] slot_last(input int slots);
    logic [SLOT_W-1:0] last;
    last = SLOT_W'(slots - 1);
    return last;
  endfunction

endpackage

// File: rtl/opl_slot_cnt.sv
// Global slot counter and zero flag. Every ring controller instantiates
// this so that all parameter rings stay aligned to the same slot index.
module opl_slot_cnt
  import opl_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output logic [SLOT_W-1:0] slot,
  output logic              zero
);

  localparam logic [SLOT_W-1:0] LAST = slot_last(SLOTS);

  logic [SLOT_W-1:0] slot_reg;

  // Advance one slot per cen tick, wrapping from the last slot to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
    end else if (cen) begin
      slot_reg <= (slot_reg == LAST) ? '0 : slot_reg + SLOT_W'(1);
    end
  end

  assign slot = slot_reg;
  assign zero = (slot_reg == '0);

endmodule

// File: rtl/opl_slot_ring_wr.sv
// Write-side controller for an external SLOTS-stage, cen-gated parameter
// ring. It recirculates the ring and splices a CPU write in at the moment
// the target slot passes. After reset it fills the whole ring with RSTVAL.
// SLOTS must lie in 3..32.
module opl_slot_ring_wr
  import opl_pkg::*;
#(
  parameter int   WIDTH  = 8,
  parameter int   SLOTS  = SLOTS_DEF,
  parameter logic RSTVAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wr_req,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_busy,
  output logic              wr_done,
  output logic              wr_err,
  input  logic [WIDTH-1:0]  ring_drop,
  output logic [WIDTH-1:0]  ring_din,
  output logic [SLOT_W-1:0] slot,
  output logic              zero,
  output logic [WIDTH-1:0]  cur_data
);

  localparam logic [SLOT_W-1:0] LAST = slot_last(SLOTS);

  ring_state_t       state_reg, state_next;
  logic [SLOT_W-1:0] init_cnt_reg, init_cnt_next;
  logic [SLOT_W-1:0] pend_slot_reg, pend_slot_next;
  logic [WIDTH-1:0]  pend_data_reg, pend_data_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [SLOT_W-1:0] slot_cur;
  logic              slot_match;

  opl_slot_cnt #(
    .SLOTS (SLOTS)
  ) u_slot_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .slot (slot_cur),
    .zero (zero)
  );

  assign slot       = slot_cur;
  assign cur_data   = ring_drop;
  assign slot_match = (slot_cur == pend_slot_reg);

  // State and pending-write registers; reset restarts initialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      pend_slot_reg <= '0;
      pend_data_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      pend_slot_reg <= pend_slot_next;
      pend_data_reg <= pend_data_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic and ring input mux (recirculate unless filling/splicing).
  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    pend_slot_next = pend_slot_reg;
    pend_data_next = pend_data_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    ring_din       = ring_drop;
    wr_busy        = 1'b1;

    case (state_reg)
      ST_INIT: begin
        ring_din = {WIDTH{RSTVAL}};
        if (cen) begin
          if (init_cnt_reg == LAST) begin
            init_cnt_next = '0;
            state_next    = ST_IDLE;
          end else begin
            init_cnt_next = init_cnt_reg + SLOT_W'(1);
          end
        end
      end

      ST_IDLE: begin
        wr_busy = 1'b0;
        if (wr_req) begin
          if (wr_slot <= LAST) begin
            pend_slot_next = wr_slot;
            pend_data_next = wr_data;
            state_next     = ST_PEND;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ST_PEND: begin
        if (slot_match) begin
          ring_din = pend_data_reg;
        end
        // The ring only captures its input on cen, so only then is the splice done.
        if (cen && slot_match) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign wr_done = done_reg;
  assign wr_err  = err_reg;

endmodule

// File: tb/tb_opl_slot_ring_wr.sv
// Testbench for opl_slot_ring_wr: external delay line, a slot-indexed
// reference model of the ring contents, table-driven write vectors,
// hand-written corner sequences and a randomized phase.
module tb_opl_slot_ring_wr;

  localparam int               WIDTH    = 8;
  localparam int               SLOTS    = 18;
  localparam logic [WIDTH-1:0] RST_WORD = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, cen, wr_req;
  logic [4:0]       wr_slot;
  logic [WIDTH-1:0] wr_data;
  logic             wr_busy, wr_done, wr_err, zero;
  logic [WIDTH-1:0] ring_drop, ring_din, cur_data;
  logic [4:0]       slot;

  opl_slot_ring_wr #(
    .WIDTH  (WIDTH),
    .SLOTS  (SLOTS),
    .RSTVAL (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .wr_req    (wr_req),
    .wr_slot   (wr_slot),
    .wr_data   (wr_data),
    .wr_busy   (wr_busy),
    .wr_done   (wr_done),
    .wr_err    (wr_err),
    .ring_drop (ring_drop),
    .ring_din  (ring_din),
    .slot      (slot),
    .zero      (zero),
    .cur_data  (cur_data)
  );

  // External SLOTS-stage cen-gated delay line, optionally pre-filled.
  logic             prefill;
  logic [WIDTH-1:0] line [SLOTS];
  assign ring_drop = line[SLOTS-1];

  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < SLOTS; i++) line[i] <= 8'hAA;
    end else if (cen) begin
      line[0] <= ring_din;
      for (int i = 1; i < SLOTS; i++) line[i] <= line[i-1];
    end
  end

  // Reference model: ring contents indexed by slot, plus pending write.
  int               checks, failures;
  bit               m_known, m_pend, m_done, m_err;
  int               m_init_left, m_slot, m_pend_slot;
  logic [WIDTH-1:0] m_pend_data;
  logic [WIDTH-1:0] mem [SLOTS];

  bit               obs_busy, obs_done, obs_err;
  logic [WIDTH-1:0] obs_cur;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] exp_din;
    obs_busy = wr_busy;
    obs_done = wr_done;
    obs_err  = wr_err;
    obs_cur  = cur_data;
    if (m_known) begin
      chk("slot", int'(slot), m_slot);
      chk("zero", int'(zero), int'(m_slot == 0));
      chk("wr_busy", int'(wr_busy), int'(m_init_left > 0 || m_pend));
      chk("wr_done", int'(wr_done), int'(m_done));
      chk("wr_err", int'(wr_err), int'(m_err));
      if (m_init_left > 0) exp_din = RST_WORD;
      else if (m_pend && m_pend_slot == m_slot) exp_din = m_pend_data;
      else exp_din = ring_drop;
      chk("ring_din", int'(ring_din), int'(exp_din));
      if (m_init_left == 0) chk("cur_data", int'(cur_data), int'(mem[m_slot]));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_known     = 1;
      m_init_left = SLOTS;
      m_pend      = 0;
      m_slot      = 0;
      m_done      = 0;
      m_err       = 0;
    end else if (m_known) begin
      m_done = 0;
      m_err  = 0;
      if (m_init_left > 0) begin
        if (cen) begin
          mem[m_slot] = RST_WORD;
          m_init_left--;
        end
      end else if (m_pend) begin
        if (cen && m_slot == m_pend_slot) begin
          mem[m_slot] = m_pend_data;
          m_pend = 0;
          m_done = 1;
        end
      end else if (wr_req) begin
        if (int'(wr_slot) < SLOTS) begin
          m_pend      = 1;
          m_pend_slot = int'(wr_slot);
          m_pend_data = wr_data;
        end else begin
          m_err = 1;
        end
      end
      if (cen) m_slot = (m_slot + 1) % SLOTS;
    end
  endtask

  // One clk: sample at negedge, model advances at posedge, inputs change after.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Run with cen=1 until the DUT slot for the coming cycle equals target.
  task automatic nav(input int target);
    cen    = 1'b1;
    wr_req = 1'b0;
    for (int k = 0; k < 40 && int'(slot) != target; k++) step();
    chk("nav_slot", int'(slot), target);
  endtask

  typedef struct {
    int               start;
    int               wslot;
    logic [WIDTH-1:0] data;
    int               ticks;
    bit               err;
  } vec_t;

  vec_t vecs [7];
  int   n, done_cnt;
  bit   done_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 5, 8'h5C, 2, 1'b0};
    vecs[1] = '{2, 2, 8'hA1, 18, 1'b0};
    vecs[2] = '{17, 0, 8'h3E, 1, 1'b0};
    vecs[3] = '{0, 17, 8'hC7, 17, 1'b0};
    vecs[4] = '{4, 20, 8'hFF, 0, 1'b1};
    vecs[5] = '{9, 31, 8'h12, 0, 1'b1};
    vecs[6] = '{10, 18, 8'h34, 0, 1'b1};

    checks = 0; failures = 0;
    m_known = 0; m_pend = 0; m_done = 0; m_err = 0;
    m_init_left = 0; m_slot = 0; m_pend_slot = 0; m_pend_data = '0;
    for (int i = 0; i < SLOTS; i++) mem[i] = 8'hAA;

    // Reset for one clk with the ring pre-filled with 0xAA.
    rst = 1'b1; cen = 1'b0; wr_req = 1'b0; wr_slot = '0; wr_data = '0; prefill = 1'b1;
    step();
    prefill = 1'b0; rst = 1'b0; cen = 1'b1;

    // Busy for exactly SLOTS cen-ticks, then the ring reads back RSTVAL.
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!obs_busy) break;
      n++;
    end
    chk("init_busy_ticks", n, SLOTS);
    for (int k = 0; k < SLOTS; k++) begin
      step();
      chk("init_ring", int'(obs_cur), int'(RST_WORD));
    end

    // Table-driven writes with cen every clk.
    for (int v = 0; v < 7; v++) begin
      nav(vecs[v].start);
      wr_req = 1'b1; wr_slot = 5'(vecs[v].wslot); wr_data = vecs[v].data;
      step();
      wr_req = 1'b0;
      if (vecs[v].err) begin
        step();
        chk("err_pulse", int'(obs_err), 1);
        chk("err_not_busy", int'(obs_busy), 0);
      end else begin
        n = 0; done_seen = 0;
        for (int k = 0; k < 40; k++) begin
          step();
          if (obs_done) begin done_seen = 1; break; end
          n++;
        end
        chk("done_seen", int'(done_seen), 1);
        chk("splice_ticks", n, vecs[v].ticks);
        nav(vecs[v].wslot);
        step();
        chk("readback", int'(obs_cur), int'(vecs[v].data));
      end
      $display("vec %0d start=%0d slot=%0d data=%0h ticks=%0d", v, vecs[v].start,
               vecs[v].wslot, vecs[v].data, n);
    end

    // Sparse cen: write slot 0 while slot=17, cen on every 4th clk.
    nav(17);
    for (int i = 0; i < 10; i++) begin
      cen     = (i == 4 || i == 8);
      wr_req  = (i == 0);
      wr_slot = 5'd0; wr_data = 8'h9D;
      step();
      chk("sparse_done", int'(obs_done), int'(i == 9));
      chk("sparse_slot", int'(slot), (i < 4) ? 17 : ((i < 8) ? 0 : 1));
    end
    wr_req = 1'b0;
    nav(0);
    step();
    chk("sparse_readback", int'(obs_cur), 8'h9D);
    $display("sparse cen write slot 0 data 9d");

    // Second request during PEND, held through the splice clk, is dropped.
    nav(4);
    wr_req = 1'b1; wr_slot = 5'd10; wr_data = 8'h11;
    step();
    for (int i = 0; i < 6; i++) begin
      wr_slot = 5'd12; wr_data = 8'h33;
      step();
      chk("busy_no_done", int'(obs_done), 0);
    end
    wr_req = 1'b0;
    step();
    chk("busy_done", int'(obs_done), 1);
    nav(10);
    step();
    chk("busy_first_value", int'(obs_cur), 8'h11);
    $display("busy drop: slot 10 holds %0h", obs_cur);

    // Reset while a write is pending: no done, ring re-initialises.
    nav(0);
    wr_req = 1'b1; wr_slot = 5'd15; wr_data = 8'h77;
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_done) done_cnt++;
    end
    chk("rst_pend_no_done", done_cnt, 0);
    nav(15);
    step();
    chk("rst_pend_ring", int'(obs_cur), int'(RST_WORD));
    nav(5);
    step();
    chk("rst_pend_ring5", int'(obs_cur), int'(RST_WORD));
    $display("reset mid-pend: done pulses=%0d", done_cnt);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 399) == 0);
      cen     = ($urandom_range(0, 2) != 0);
      wr_req  = ($urandom_range(0, 3) == 0);
      wr_slot = 5'($urandom_range(0, 23));
      wr_data = 8'($urandom);
      step();
    end
    rst = 1'b0; wr_req = 1'b0;
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opl_slot_ring_wr.md
Name: opl_slot_ring_wr

Overview:
- Write-side controller for per-slot parameter rings in the OPL core.
- Each slot parameter (for example TL or multiplier) is held in an external SLOTS-stage, cen-gated delay line.
- This block sits directly upstream of that delay line. It drives the line's input and recirculates its output.
- It splices a CPU write into the ring at the instant the target slot passes, and generates the global slot counter and zero flag that the rings stay aligned to.

Parameters:
- WIDTH, 8: data width of one ring entry.
- SLOTS, 18: ring length and slot count; must be >2 and ≤32.
- RSTVAL, 0: value written to every ring entry during initialisation (replicated across WIDTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  slot-rate clock enable; all state advances only when cen=1.
- wr_req  in  1  write request, sampled every clk.
- wr_slot  in  5  target slot index, 0..SLOTS-1.
- wr_data  in  WIDTH  value to store.
- wr_busy  out  1  high in INIT or PEND; requests are ignored while high.
- wr_done  out  1  one-clk pulse after the splice.
- wr_err  out  1  one-clk pulse when a request has wr_slot ≥ SLOTS.
- ring_drop  in  WIDTH  output of the external delay line.
- ring_din  out  WIDTH  input to the external delay line (combinational).
- slot  out  5  current slot index.
- zero  out  1  high while slot==0.
- cur_data  out  WIDTH  value of the current slot (equals ring_drop).

Behaviour:
- Slot counter:
  - On cen, increments and wraps from SLOTS-1 to 0. Holds when cen=0.
  - Reset value is 0.
  - Alignment: data driven on ring_din during a cen cycle with slot==s reappears on ring_drop exactly SLOTS cen-ticks later, when slot==s again.
- State machine: INIT, IDLE, PEND.
- Reset:
  - State goes to INIT with an init counter of 0; slot=0; wr_done=0; wr_err=0; pend registers=0.
  - rst held for several clks keeps these values.
  - rst mid-PEND discards the pending write, with no wr_done.
- INIT:
  - ring_din=RSTVAL; wr_busy=1.
  - The init counter increments on each cen.
  - After SLOTS cen-ticks (counter reaches SLOTS-1 on a cen), go to IDLE. The whole ring then holds RSTVAL, whatever the rst pulse length was.
- IDLE:
  - ring_din=ring_drop (recirculate); wr_busy=0.
  - wr_req with wr_slot<SLOTS: latch slot and data, go to PEND next clk. This happens independent of cen.
  - wr_req with wr_slot≥SLOTS: wr_err pulse next clk, stay IDLE, nothing latched.
- PEND:
  - wr_busy=1.
  - If slot==pend_slot, ring_din=pend_data; otherwise ring_din=ring_drop.
  - On a clk with cen=1 and slot==pend_slot: go to IDLE and pulse wr_done on the next clk.
  - cen=0 never completes a splice.
- Latency:
  - A request is never spliced in the clk it is accepted.
  - Splice happens at the first cen where slot==pend_slot after latching: 1 to SLOTS cen-ticks.
  - cur_data shows the new value SLOTS cen-ticks after the splice.
- Simultaneous events:
  - wr_req while wr_busy=1 is dropped silently; no err, no done.
  - wr_req in the same clk that PEND completes is dropped, because wr_busy is still 1.
- Unaffected by writes: zero and slot.
- Widths: wr_slot compare is unsigned 5-bit. SLOTS-1 is truncated to 5 bits.

Decomposition:
- Shared package opl_pkg holds:
  - default SLOTS (18), slot index width (5);
  - state encoding constants ST_INIT, ST_IDLE, ST_PEND.
- One natural sub-module: opl_slot_cnt (slot counter plus zero flag). The team instantiates it in other ring controllers so all rings share identical alignment.
- The delay line stays external. This block connects to it only through ring_din and ring_drop.

Test Plan:
- Reset and init:
  - Stimulus: rst for 1 clk; cen every clk; ring pre-filled with 0xAA; RSTVAL=0; SLOTS=18.
  - Required: wr_busy stays 1 for exactly 18 cen-ticks; then every ring_drop value over the next 18 ticks is 0x00.
- Basic write:
  - Stimulus: in IDLE at slot=3, write slot 5 data 0x5C.
  - Required: splice at slot=5, 2 cen later; wr_done the following clk; cur_data=0x5C when slot=5 on the next rotation; other slots unchanged.
- Wrap-around latency:
  - Stimulus: request slot 2, accepted while slot=2 (splice not possible that clk).
  - Required: splice 18 cen-ticks later at slot=2.
- Sparse cen:
  - Stimulus: cen every 4th clk; write slot 0 while slot=17.
  - Required: splice on the next cen with slot=0; the cen=0 clks in between change nothing.
- Errors and busy:
  - Stimulus: wr_slot=20.
  - Required: wr_err pulse, no PEND.
  - Stimulus: a second wr_req during PEND.
  - Required: ignored; only the first value appears in the ring.
- Reset mid-PEND:
  - Stimulus: rst asserted before the match.
  - Required: no wr_done; the ring re-initialises to RSTVAL.
